// File: rtl/ct_apb_slv_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ct_apb_slv_seq_ctrl                                        |
// | Description : APB sequencer/decoder. One upstream APB requester is       |
// |               fanned out to NUM_SLV register-block slaves. The module    |
// |               decodes the address, runs the downstream SETUP/ACCESS      |
// |               handshake and returns data or an error upstream. Address   |
// |               misses and slaves that never answer become a clean error   |
// |               response.                                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   apb_clk    in   1            clock, rising edge                         |
// |   apbrst     in   1            synchronous active-high reset              |
// |   m_psel     in   1            upstream select                            |
// |   m_penable  in   1            upstream enable                            |
// |   m_pwrite   in   1            upstream write strobe                      |
// |   m_paddr    in   ADDR_W       upstream address                           |
// |   m_pwdata   in   32           upstream write data                        |
// |   m_pready   out  1            upstream ready, one-cycle pulse            |
// |   m_prdata   out  32           upstream read data (0 unless m_pready)     |
// |   m_pslverr  out  1            upstream error (0 unless m_pready)         |
// |   s_psel     out  NUM_SLV      one-hot downstream select                  |
// |   s_penable  out  1            downstream enable                          |
// |   s_pwrite   out  1            captured write strobe                      |
// |   s_paddr    out  ADDR_W       captured address                           |
// |   s_pwdata   out  32           captured write data                        |
// |   s_pready   in   NUM_SLV      per-slave ready                            |
// |   s_prdata   in   NUM_SLV*32   per-slave read data, slave i at [32*i+:32] |
// |   s_perr     in   NUM_SLV      per-slave error, sampled with s_pready     |
// +--------------------------------------------------------------------------+

module ct_apb_slv_seq_ctrl #(
    parameter int                NUM_SLV   = 4,
    parameter int                ADDR_W    = 32,
    parameter int                SLV_LOG2  = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1800_0000,
    parameter int                TIMEOUT   = 16
) (
    input  logic                    apb_clk,
    input  logic                    apbrst,
    input  logic                    m_psel,
    input  logic                    m_penable,
    input  logic                    m_pwrite,
    input  logic [ADDR_W-1:0]       m_paddr,
    input  logic [31:0]             m_pwdata,
    output logic                    m_pready,
    output logic [31:0]             m_prdata,
    output logic                    m_pslverr,
    output logic [NUM_SLV-1:0]      s_psel,
    output logic                    s_penable,
    output logic                    s_pwrite,
    output logic [ADDR_W-1:0]       s_paddr,
    output logic [31:0]             s_pwdata,
    input  logic [NUM_SLV-1:0]      s_pready,
    input  logic [NUM_SLV*32-1:0]   s_prdata,
    input  logic [NUM_SLV-1:0]      s_perr
);

    localparam int IW   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int HI   = SLV_LOG2 + IW;
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t               r_state,   w_nxt_state;
    logic [NUM_SLV-1:0]   r_psel,    w_nxt_psel;
    logic                 r_penable, w_nxt_penable;
    logic                 r_pwrite,  w_nxt_pwrite;
    logic [ADDR_W-1:0]    r_paddr,   w_nxt_paddr;
    logic [31:0]          r_pwdata,  w_nxt_pwdata;
    logic                 r_pready,  w_nxt_pready;
    logic [31:0]          r_prdata,  w_nxt_prdata;
    logic                 r_pslverr, w_nxt_pslverr;
    logic [IW-1:0]        r_idx,     w_nxt_idx;
    logic [TO_W-1:0]      r_tout,    w_nxt_tout;

    logic [IW-1:0]        w_idx;
    logic                 w_hit;
    logic [NUM_SLV-1:0]   w_onehot;
    logic                 w_sel_ready;
    logic                 w_sel_err;
    logic [31:0]          w_sel_data;

    // Address decode of the live upstream address; only used in IDLE.
    // A window index beyond NUM_SLV is a miss even inside the aligned span.
    assign w_idx = m_paddr[SLV_LOG2 +: IW];
    assign w_hit = (m_paddr[ADDR_W-1:HI] == BASE_ADDR[ADDR_W-1:HI]) &&
                   ({1'b0, w_idx} < (IW+1)'(NUM_SLV));

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_idx == IW'(i)) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Response mux for the captured slave index; other slaves are ignored.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == IW'(i)) begin
                w_sel_ready = s_pready[i];
                w_sel_err   = s_perr[i];
                w_sel_data  = s_prdata[32*i +: 32];
            end
        end
    end

    // Next-state and next-output logic; every output is registered so the
    // values computed here appear on the ports one edge later.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_psel    = r_psel;
        w_nxt_penable = r_penable;
        w_nxt_pwrite  = r_pwrite;
        w_nxt_paddr   = r_paddr;
        w_nxt_pwdata  = r_pwdata;
        w_nxt_pready  = 1'b0;
        w_nxt_prdata  = '0;
        w_nxt_pslverr = 1'b0;
        w_nxt_idx     = r_idx;
        w_nxt_tout    = r_tout;

        case (r_state)
            ST_IDLE: begin
                w_nxt_psel    = '0;
                w_nxt_penable = 1'b0;
                if (m_psel && !m_penable) begin
                    w_nxt_paddr  = m_paddr;
                    w_nxt_pwrite = m_pwrite;
                    w_nxt_pwdata = m_pwdata;
                    w_nxt_idx    = w_idx;
                    if (w_hit) begin
                        w_nxt_state = ST_SETUP;
                        w_nxt_psel  = w_onehot;
                    end else begin
                        w_nxt_state   = ST_RESP;
                        w_nxt_pready  = 1'b1;
                        w_nxt_pslverr = 1'b1;
                    end
                end
            end

            ST_SETUP: begin
                w_nxt_state   = ST_ACCESS;
                w_nxt_penable = 1'b1;
                w_nxt_tout    = '0;
            end

            ST_ACCESS: begin
                if (w_sel_ready) begin
                    // A ready on the final timeout cycle still gives a normal response.
                    w_nxt_state   = ST_RESP;
                    w_nxt_psel    = '0;
                    w_nxt_penable = 1'b0;
                    w_nxt_pready  = 1'b1;
                    w_nxt_prdata  = r_pwrite ? 32'h0 : w_sel_data;
                    w_nxt_pslverr = w_sel_err;
                end else if ((TIMEOUT != 0) && (r_tout == TO_LAST)) begin
                    w_nxt_state   = ST_RESP;
                    w_nxt_psel    = '0;
                    w_nxt_penable = 1'b0;
                    w_nxt_pready  = 1'b1;
                    w_nxt_pslverr = 1'b1;
                end else if (r_tout != TO_MAX) begin
                    w_nxt_tout = r_tout + TO_W'(1);
                end
            end

            ST_RESP: begin
                w_nxt_state   = ST_IDLE;
                w_nxt_psel    = '0;
                w_nxt_penable = 1'b0;
            end

            default: begin
                w_nxt_state   = ST_IDLE;
                w_nxt_psel    = '0;
                w_nxt_penable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge apb_clk) begin
        if (apbrst) begin
            r_state   <= ST_IDLE;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            r_idx     <= '0;
            r_tout    <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_psel    <= w_nxt_psel;
            r_penable <= w_nxt_penable;
            r_pwrite  <= w_nxt_pwrite;
            r_paddr   <= w_nxt_paddr;
            r_pwdata  <= w_nxt_pwdata;
            r_pready  <= w_nxt_pready;
            r_prdata  <= w_nxt_prdata;
            r_pslverr <= w_nxt_pslverr;
            r_idx     <= w_nxt_idx;
            r_tout    <= w_nxt_tout;
        end
    end

    assign m_pready  = r_pready;
    assign m_prdata  = r_prdata;
    assign m_pslverr = r_pslverr;
    assign s_psel    = r_psel;
    assign s_penable = r_penable;
    assign s_pwrite  = r_pwrite;
    assign s_paddr   = r_paddr;
    assign s_pwdata  = r_pwdata;

endmodule

`default_nettype wire
